// File: rtl/i2s_rx_frame_reader_pkg.sv
// Shared constants and reader state type for the I2S receive-buffer read path.
package i2s_pkg;

    localparam int unsigned FRAME_BITS      = 256;
    localparam int unsigned WORD_BITS       = 32;
    localparam int unsigned WORDS_PER_FRAME = FRAME_BITS / WORD_BITS;
    localparam int unsigned BIT_IDX_W       = $clog2(WORD_BITS);
    localparam int unsigned WORD_IDX_W      = $clog2(WORDS_PER_FRAME);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_FETCH      = 2'd2,
        ST_PRESENT    = 2'd3
    } reader_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/i2s_word_deserializer.sv
// Shifts 1-bit RAM read data into a 32-bit MSB-first word, compensating the
// one-cycle read latency and strobing done when the final bit is captured.
module i2s_word_deserializer
    import i2s_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 rd_en_i,
    input  logic                 rd_last_i,
    input  logic                 rd_data_i,
    output logic [WORD_BITS-1:0] word_o,
    output logic                 done_o
);

    logic                 en_q, en_d;
    logic                 last_q, last_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;

    // en_q/last_q mark the cycle in which the RAM returns data for a read issued
    // one cycle earlier; a flush drops any read still in flight.
    always_comb begin
        en_d    = rd_en_i & ~flush_i;
        last_d  = rd_en_i & rd_last_i & ~flush_i;
        shreg_d = shreg_q;
        if (en_q) begin
            shreg_d = {shreg_q[WORD_BITS-2:0], rd_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q    <= 1'b0;
            last_q  <= 1'b0;
            shreg_q <= '0;
        end else begin
            en_q    <= en_d;
            last_q  <= last_d;
            shreg_q <= shreg_d;
        end
    end

    assign word_o = shreg_q;
    assign done_o = last_q;

endmodule

// File: rtl/i2s_rx_frame_reader.sv
// Read-side controller for the I2S receive circular buffer: frame tracking,
// bit-serial fetch, word streaming and overrun resync.
// Optional statistics counters: define I2S_RX_FRAME_READER_STATS_EN.
module i2s_rx_frame_reader
    import i2s_pkg::*;
#(
    parameter int unsigned CIRC_BUF_BITS = 3
)
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
    output logic [CIRC_BUF_BITS+7:0] ram_read_addr_o,
    output logic                     ram_read_en_o,
    input  logic                     ram_read_data_i,
    output logic [31:0]              word_data_o,
    output logic                     word_valid_o,
    input  logic                     word_ready_i,
    output logic                     word_last_o,
    output logic                     overrun_o,
    output logic [CIRC_BUF_BITS:0]   frames_pending_o,
    output logic [15:0]              frames_read_o,
    output logic [15:0]              overrun_count_o
);

    localparam int unsigned CNT_W = BIT_IDX_W + 1;
    localparam logic [CIRC_BUF_BITS:0]   PEND_FULL = {1'b0, {CIRC_BUF_BITS{1'b1}}};
    localparam logic [CIRC_BUF_BITS:0]   PEND_ONE  = 1;
    localparam logic [CIRC_BUF_BITS-1:0] FRAME_ONE = 1;

    reader_state_e              state_q, state_d;
    logic [CIRC_BUF_BITS-1:0]   prev_good_q, prev_good_d;
    logic [CIRC_BUF_BITS-1:0]   rd_frame_q, rd_frame_d;
    logic [CIRC_BUF_BITS:0]     pending_q, pending_d;
    logic [WORD_IDX_W-1:0]      word_idx_q, word_idx_d;
    logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic                       overrun_q, overrun_d;

    logic                       new_frame;
    logic                       handshake;
    logic                       last_hs;
    logic                       overrun_evt;
    logic                       reading;
    logic                       read_last;
    logic                       flush;
    logic [WORD_BITS-1:0]       deser_word;
    logic                       deser_done;

    always_comb begin
        new_frame   = (state_q != ST_IDLE) && (last_good_frame_idx_i != prev_good_q);
        handshake   = (state_q == ST_PRESENT) && word_ready_i;
        last_hs     = handshake && (word_idx_q == WORD_IDX_W'(WORDS_PER_FRAME - 1));
        overrun_evt = new_frame && (pending_q == PEND_FULL);
        reading     = (state_q == ST_FETCH) && !bit_cnt_q[CNT_W-1];
        read_last   = reading && (bit_cnt_q[BIT_IDX_W-1:0] == '1);
    end

    always_comb begin
        state_d     = state_q;
        prev_good_d = prev_good_q;
        rd_frame_d  = rd_frame_q;
        pending_d   = pending_q;
        word_idx_d  = word_idx_q;
        bit_cnt_d   = bit_cnt_q;
        overrun_d   = 1'b0;
        flush       = 1'b0;

        if (!enable_i) begin
            state_d    = ST_IDLE;
            pending_d  = '0;
            word_idx_d = '0;
            bit_cnt_d  = '0;
            flush      = 1'b1;
        end else if (state_q == ST_IDLE) begin
            prev_good_d = last_good_frame_idx_i;
            rd_frame_d  = last_good_frame_idx_i + FRAME_ONE;
            pending_d   = '0;
            word_idx_d  = '0;
            bit_cnt_d   = '0;
            state_d     = ST_WAIT_FRAME;
        end else begin
            prev_good_d = last_good_frame_idx_i;
            if (overrun_evt) begin
                // Writer lapped us: abandon the current frame and restart on the
                // newest complete one, even over a simultaneous last-word handshake.
                overrun_d  = 1'b1;
                rd_frame_d = last_good_frame_idx_i;
                pending_d  = PEND_ONE;
                word_idx_d = '0;
                bit_cnt_d  = '0;
                flush      = 1'b1;
                state_d    = ST_FETCH;
            end else begin
                if (new_frame && !last_hs) begin
                    pending_d = pending_q + PEND_ONE;
                end else if (last_hs && !new_frame) begin
                    pending_d = pending_q - PEND_ONE;
                end

                case (state_q)
                    ST_WAIT_FRAME: begin
                        if (pending_q != '0) begin
                            word_idx_d = '0;
                            bit_cnt_d  = '0;
                            state_d    = ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (reading) begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                        if (deser_done) begin
                            state_d = ST_PRESENT;
                        end
                    end
                    ST_PRESENT: begin
                        if (handshake) begin
                            bit_cnt_d = '0;
                            if (last_hs) begin
                                rd_frame_d = rd_frame_q + FRAME_ONE;
                                word_idx_d = '0;
                                state_d    = ST_WAIT_FRAME;
                            end else begin
                                word_idx_d = word_idx_q + WORD_IDX_W'(1);
                                state_d    = ST_FETCH;
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            prev_good_q <= '0;
            rd_frame_q  <= '0;
            pending_q   <= '0;
            word_idx_q  <= '0;
            bit_cnt_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_good_q <= prev_good_d;
            rd_frame_q  <= rd_frame_d;
            pending_q   <= pending_d;
            word_idx_q  <= word_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    i2s_word_deserializer u_deser (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush),
        .rd_en_i   (reading),
        .rd_last_i (read_last),
        .rd_data_i (ram_read_data_i),
        .word_o    (deser_word),
        .done_o    (deser_done)
    );

    always_comb begin
        ram_read_en_o    = reading;
        ram_read_addr_o  = reading ? {rd_frame_q, word_idx_q, bit_cnt_q[BIT_IDX_W-1:0]} : '0;
        word_valid_o     = (state_q == ST_PRESENT);
        word_data_o      = word_valid_o ? deser_word : '0;
        word_last_o      = word_valid_o && (word_idx_q == WORD_IDX_W'(WORDS_PER_FRAME - 1));
        overrun_o        = overrun_q;
        frames_pending_o = pending_q;
    end

`ifdef I2S_RX_FRAME_READER_STATS_EN
    logic [15:0] frames_read_q, frames_read_d;
    logic [15:0] ovr_count_q, ovr_count_d;

    always_comb begin
        frames_read_d = frames_read_q;
        ovr_count_d   = ovr_count_q;
        if (!enable_i) begin
            frames_read_d = '0;
            ovr_count_d   = '0;
        end else if (overrun_evt) begin
            ovr_count_d = sat_inc16(ovr_count_q);
        end else if (last_hs) begin
            frames_read_d = sat_inc16(frames_read_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frames_read_q <= '0;
            ovr_count_q   <= '0;
        end else begin
            frames_read_q <= frames_read_d;
            ovr_count_q   <= ovr_count_d;
        end
    end

    assign frames_read_o   = frames_read_q;
    assign overrun_count_o = ovr_count_q;
`else
    assign frames_read_o   = '0;
    assign overrun_count_o = '0;
`endif

endmodule

// File: tb/tb_i2s_rx_frame_reader.sv
// Self-checking bench for i2s_rx_frame_reader: cycle-level reference model plus
// directed scenarios with literal expectations.
module tb_i2s_rx_frame_reader;

    localparam int N  = 3;
    localparam int NF = 1 << N;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           enable_i;
    logic [N-1:0]   last_good_frame_idx_i;
    logic [N+7:0]   ram_read_addr_o;
    logic           ram_read_en_o;
    logic           ram_read_data_i = 1'b0;
    logic [31:0]    word_data_o;
    logic           word_valid_o;
    logic           word_ready_i;
    logic           word_last_o;
    logic           overrun_o;
    logic [N:0]     frames_pending_o;
    logic [15:0]    frames_read_o;
    logic [15:0]    overrun_count_o;

    always #5 clk = ~clk;

    i2s_rx_frame_reader #(.CIRC_BUF_BITS(N)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .enable_i              (enable_i),
        .last_good_frame_idx_i (last_good_frame_idx_i),
        .ram_read_addr_o       (ram_read_addr_o),
        .ram_read_en_o         (ram_read_en_o),
        .ram_read_data_i       (ram_read_data_i),
        .word_data_o           (word_data_o),
        .word_valid_o          (word_valid_o),
        .word_ready_i          (word_ready_i),
        .word_last_o           (word_last_o),
        .overrun_o             (overrun_o),
        .frames_pending_o      (frames_pending_o),
        .frames_read_o         (frames_read_o),
        .overrun_count_o       (overrun_count_o)
    );

    // RAM contents: bit n of the buffer lives at mem[n]; 1-cycle read latency.
    logic mem [0:NF*256-1];
    always @(posedge clk) ram_read_data_i <= ram_read_en_o ? mem[ram_read_addr_o] : 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input int frame, input int word);
        logic [31:0] w;
        for (int b = 0; b < 32; b++) w[31-b] = mem[frame*256 + word*32 + b];
        return w;
    endfunction

    // Reference model: m_t counts cycles since the current word fetch began
    // (-1 = waiting for a frame); the word is presented once m_t reaches 33.
    bit m_on = 0, m_ovr = 0, m_started = 0;
    int m_prev = 0, m_frame = 0, m_pending = 0, m_word = 0, m_t = -1;
    int m_frames_read = 0, m_ovr_count = 0;

    always @(posedge clk) begin : model
        int  lg, old_pend;
        bit  nf, hs, lasths;
        lg = int'(last_good_frame_idx_i);
        if (rst_i || !enable_i) begin
            m_on = 0; m_pending = 0; m_t = -1; m_word = 0; m_ovr = 0;
            m_frames_read = 0; m_ovr_count = 0;
        end else if (!m_on) begin
            m_on = 1; m_prev = lg; m_frame = (lg + 1) % NF; m_pending = 0;
            m_t = -1; m_word = 0; m_ovr = 0;
        end else begin
            nf       = (lg != m_prev);
            hs       = (m_t == 33) && word_ready_i;
            lasths   = hs && (m_word == 7);
            old_pend = m_pending;
            m_ovr    = 0;
            if (nf && old_pend == NF - 1) begin
                m_ovr = 1; m_frame = lg; m_pending = 1; m_word = 0; m_t = 0;
                if (m_ovr_count < 65535) m_ovr_count++;
            end else begin
                m_pending = old_pend + int'(nf) - int'(lasths);
                if (m_t < 0) begin
                    if (old_pend != 0) begin m_t = 0; m_word = 0; end
                end else if (m_t < 33) begin
                    m_t++;
                end else if (hs) begin
                    if (lasths) begin
                        m_frame = (m_frame + 1) % NF; m_t = -1;
                        if (m_frames_read < 65535) m_frames_read++;
                    end else begin
                        m_word++; m_t = 0;
                    end
                end
            end
            m_prev = lg;
        end
        m_started = 1;
    end

    bit c_rd, c_valid;
    always @(negedge clk) begin
        if (m_started) begin
            c_rd    = m_on && m_t >= 0 && m_t < 32;
            c_valid = m_on && m_t == 33;
            check("read_en", ram_read_en_o, c_rd);
            if (c_rd) check("read_addr", ram_read_addr_o, m_frame*256 + m_word*32 + m_t);
            else if (!m_on) check("idle_addr", ram_read_addr_o, 0);
            check("valid", word_valid_o, c_valid);
            if (c_valid) check("data", word_data_o, exp_word(m_frame, m_word));
            else if (!m_on) check("idle_data", word_data_o, 0);
            check("last", word_last_o, c_valid && m_word == 7);
            check("overrun", overrun_o, m_ovr);
            check("pending", frames_pending_o, m_pending);
`ifdef I2S_RX_FRAME_READER_STATS_EN
            check("frames_read", frames_read_o, m_frames_read);
            check("overrun_count", overrun_count_o, m_ovr_count);
`else
            check("frames_read", frames_read_o, 0);
            check("overrun_count", overrun_count_o, 0);
`endif
        end
    end

    function automatic bit sig(input int sel);
        case (sel)
            0:       return word_valid_o;
            1:       return ram_read_en_o;
            default: return overrun_o;
        endcase
    endfunction

    task automatic wait_until(input int sel, input int budget, input string name, output int cycles);
        cycles = 0;
        while (!sig(sel) && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (!sig(sel)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout, still 0 after %0d cycles", name, budget);
        end
    endtask

    task automatic take_word(input int w);
        int c;
        wait_until(0, 80, "wait_valid", c);
        check("last_flag", word_last_o, (w == 7));
        word_ready_i = 1'b1;
        @(negedge clk);
        word_ready_i = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        logic [31:0] d0;
        int reads;
        logic [N+7:0] a;

        for (int i = 0; i < NF*256; i++) mem[i] = 1'($urandom_range(0, 1));
        // Frame 4: bit n = n[0]; address 32k maps to word bit 31, giving 0x55555555.
        for (int n = 0; n < 256; n++) mem[4*256 + n] = 1'(n & 1);

        rst_i = 1'b1; enable_i = 1'b0; last_good_frame_idx_i = 3'd3; word_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_read_en", ram_read_en_o, 0);
        check("rst_addr", ram_read_addr_o, 0);
        check("rst_valid", word_valid_o, 0);
        check("rst_data", word_data_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_pending", frames_pending_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        enable_i = 1'b1;
        repeat (3) @(negedge clk);
        check("en_pending0", frames_pending_o, 0);
        check("en_no_read", ram_read_en_o, 0);

        // One frame completes -> read frame 4
        last_good_frame_idx_i = 3'd4;
        @(negedge clk);
        check("pending_after_frame", frames_pending_o, 1);
        wait_until(1, 10, "wait_fetch", c);
        check("first_addr", ram_read_addr_o, 11'd1024);
        wait_until(0, 60, "wait_first_valid", c);
        check("fetch_to_valid", c, 33);
        check("first_word", word_data_o, 32'h5555_5555);

        // Backpressure: 100 cycles with ready low
        d0 = word_data_o;
        reads = 0;
        repeat (100) begin
            @(negedge clk);
            reads += int'(ram_read_en_o);
            check("stall_data", word_data_o, d0);
        end
        check("stall_reads", reads, 0);
        check("stall_valid", word_valid_o, 1);

        for (int w = 0; w < 8; w++) take_word(w);
        check("pending_after_read", frames_pending_o, 0);
`ifdef I2S_RX_FRAME_READER_STATS_EN
        check("frames_read_1", frames_read_o, 1);
`endif

        // Seven completions while stalled, then an eighth -> overrun
        for (int k = 0; k < 7; k++) begin
            last_good_frame_idx_i = N'((5 + k) % NF);
            repeat (3) @(negedge clk);
        end
        check("pending_full", frames_pending_o, 7);
        check("no_overrun_yet", overrun_o, 0);
        last_good_frame_idx_i = 3'd4;
        @(negedge clk);
        check("overrun_pulse", overrun_o, 1);
        check("overrun_pending", frames_pending_o, 1);
        check("overrun_addr", ram_read_addr_o, 11'd1024);
`ifdef I2S_RX_FRAME_READER_STATS_EN
        check("overrun_count_1", overrun_count_o, 1);
`endif
        @(negedge clk);
        check("overrun_one_cycle", overrun_o, 0);

        // Last-word handshake coincident with a new frame
        for (int w = 0; w < 7; w++) take_word(w);
        wait_until(0, 80, "wait_last_word", c);
        check("last_word_flag", word_last_o, 1);
        word_ready_i = 1'b1;
        last_good_frame_idx_i = 3'd5;
        @(negedge clk);
        word_ready_i = 1'b0;
        check("pending_unchanged", frames_pending_o, 1);

        // Disable mid-fetch, then re-enable
        wait_until(1, 10, "wait_fetch5", c);
        check("frame5_addr", ram_read_addr_o, 11'd1280);
        repeat (5) @(negedge clk);
        enable_i = 1'b0;
        @(negedge clk);
        check("dis_read_en", ram_read_en_o, 0);
        check("dis_addr", ram_read_addr_o, 0);
        check("dis_valid", word_valid_o, 0);
        check("dis_data", word_data_o, 0);
        check("dis_last", word_last_o, 0);
        check("dis_overrun", overrun_o, 0);
        check("dis_pending", frames_pending_o, 0);
        check("dis_frames_read", frames_read_o, 0);
        check("dis_overrun_count", overrun_count_o, 0);
        repeat (2) @(negedge clk);
        enable_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reen_pending", frames_pending_o, 0);
        check("reen_no_read", ram_read_en_o, 0);
        last_good_frame_idx_i = 3'd6;
        wait_until(1, 10, "wait_fetch6", c);
        a = ram_read_addr_o;
        check("resync_addr", a, 11'd1536);
        word_ready_i = 1'b1;
        repeat (300) @(negedge clk);
        word_ready_i = 1'b0;
        check("drain_pending", frames_pending_o, 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
